snoop_bus_arbiter: RTL

//  Round-robin owner of the shared snooping bus between processor0/1/2 and memory.

---
 rtl/snoop_bus_arbiter.sv | 256 +++++++++++++++++++++++++
 1 files changed

// File: rtl/snoop_bus_arbiter.sv
// ---------------------------------------------------------------------------
// snoop_bus_arbiter
//
// Purpose
//   Round-robin owner of the shared snooping bus between three CPUs and
//   memory. One CPU is granted per transaction. Its address/op go out on the
//   bus while the other two CPUs snoop. The transaction then either completes
//   cache-to-cache (SUPPLY, memory untouched) or as a counted memory access
//   (MEM). A one-cycle done pulse goes back to the owner.
//
// Configuration
//   SNOOP_TIMEOUT_EN (macro): when defined, the snoop window ends once every
//   listener has acknowledged (acks accumulate across cycles). If that does
//   not happen within TIMEOUT_CYC cycles, snoop_err is set (sticky until
//   reset) and the transaction goes to memory. When undefined, the window is
//   a fixed SNOOP_CYC cycles, snoop_ack is ignored and snoop_err is 0.
//
// Ports
//   clock, reset           rising-edge clock, synchronous active-high reset
//   req[2:0]               per-CPU request level, held until done
//   req_op[2:0]            per-CPU op, 0=read 1=write
//   req_addr[14:0]         per-CPU 5-bit address, CPU i at [5i+4:5i]
//   snoop_hit/dirty[2:0]   listener holds the block valid / modified
//   snoop_ack[2:0]         listener finished snooping (timeout mode only)
//   grant[2:0]             one-hot bus owner
//   snoop_listen[2:0]      ~grant while snooping, else 0
//   bus_addr, bus_op       latched owner address / op
//   bus_block[1:0]         block index decoded from the latched address
//   abort_mem_accs         cache-to-cache supply cycle
//   mem_en, mem_we         memory access active / write
//   done[2:0]              one-cycle completion pulse to the owner
//   snoop_err              sticky snoop timeout flag
//   dbg_state[2:0]         FSM state (IDLE=0 SNOOP=1 SUPPLY=2 MEM=3 DONE=4)
//   dbg_hit                accumulated snoop hit for the current transaction
//
// Handshake: a CPU raises req and holds it. The arbiter samples req levels
// only in IDLE. A grant, once given, runs to completion whatever req does
// afterwards. done[owner] is the single-cycle acknowledge, after which the
// CPU may drop or re-assert req.
// ---------------------------------------------------------------------------
module snoop_bus_arbiter #(
    parameter int SNOOP_CYC   = 2,
    parameter int MEM_LAT     = 3,
    parameter int TIMEOUT_CYC = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [2:0]  req,
    input  logic [2:0]  req_op,
    input  logic [14:0] req_addr,
    input  logic [2:0]  snoop_hit,
    input  logic [2:0]  snoop_dirty,
    input  logic [2:0]  snoop_ack,
    output logic [2:0]  grant,
    output logic [2:0]  snoop_listen,
    output logic [4:0]  bus_addr,
    output logic        bus_op,
    output logic [1:0]  bus_block,
    output logic        abort_mem_accs,
    output logic        mem_en,
    output logic        mem_we,
    output logic [2:0]  done,
    output logic        snoop_err,
    output logic [2:0]  dbg_state,
    output logic        dbg_hit
);

    localparam int CW = 8;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SNOOP  = 3'd1,
        S_SUPPLY = 3'd2,
        S_MEM    = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t         state_q, state_d;
    logic [2:0]     grant_q, grant_d;
    logic [1:0]     rr_q, rr_d;
    logic [4:0]     addr_q, addr_d;
    logic           op_q, op_d;
    logic [1:0]     block_q, block_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           hit_q, hit_d;
    logic           dirty_q, dirty_d;
    logic           err_q, err_d;
`ifdef SNOOP_TIMEOUT_EN
    logic [2:0]     ack_q, ack_d;
    logic [2:0]     ack_now;
`endif

    function automatic logic [1:0] block_of(input logic [4:0] a);
        case (a)
            5'd8, 5'd10:  block_of = 2'd0;
            5'd12:        block_of = 2'd1;
            5'd14, 5'd16: block_of = 2'd2;
            default:      block_of = 2'd3;
        endcase
    endfunction

    // Round-robin pick: scan rr+1, rr+2, rr (mod 3) for the first request.
    logic [1:0] scan0, scan1, scan2;
    logic [1:0] win;
    logic [4:0] win_addr;

    always_comb begin
        case (rr_q)
            2'd0:    begin scan0 = 2'd1; scan1 = 2'd2; scan2 = 2'd0; end
            2'd1:    begin scan0 = 2'd2; scan1 = 2'd0; scan2 = 2'd1; end
            default: begin scan0 = 2'd0; scan1 = 2'd1; scan2 = 2'd2; end
        endcase
        if (req[scan0])      win = scan0;
        else if (req[scan1]) win = scan1;
        else                 win = scan2;
        case (win)
            2'd0:    win_addr = req_addr[4:0];
            2'd1:    win_addr = req_addr[9:5];
            default: win_addr = req_addr[14:10];
        endcase
    end

    // Owner's own snoop bits are masked off; the current cycle is folded in
    // so the exit decision sees the final cycle of the window.
    logic hit_now, dirty_now;
    assign hit_now   = hit_q   | (|(snoop_hit   & ~grant_q));
    assign dirty_now = dirty_q | (|(snoop_dirty & ~grant_q));

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        rr_d    = rr_q;
        addr_d  = addr_q;
        op_d    = op_q;
        block_d = block_q;
        cnt_d   = cnt_q;
        hit_d   = hit_q;
        dirty_d = dirty_q;
        err_d   = err_q;
`ifdef SNOOP_TIMEOUT_EN
        ack_d   = ack_q;
        ack_now = (ack_q | snoop_ack) & ~grant_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (|req) begin
                    grant_d = 3'b001 << win;
                    rr_d    = win;
                    addr_d  = win_addr;
                    op_d    = req_op[win];
                    block_d = block_of(win_addr);
                    hit_d   = 1'b0;
                    dirty_d = 1'b0;
`ifdef SNOOP_TIMEOUT_EN
                    ack_d   = 3'b000;
                    cnt_d   = CW'(TIMEOUT_CYC - 1);
`else
                    cnt_d   = CW'(SNOOP_CYC - 1);
`endif
                    state_d = S_SNOOP;
                end
            end
            S_SNOOP: begin
                hit_d   = hit_now;
                dirty_d = dirty_now;
                cnt_d   = cnt_q - CW'(1);
`ifdef SNOOP_TIMEOUT_EN
                ack_d = ack_now;
                if (ack_now == ~grant_q) begin
                    state_d = (!op_q && dirty_now) ? S_SUPPLY : S_MEM;
                    cnt_d   = CW'(MEM_LAT - 1);
                end else if (cnt_q == '0) begin
                    // Timed out: the memory path is always safe.
                    err_d   = 1'b1;
                    state_d = S_MEM;
                    cnt_d   = CW'(MEM_LAT - 1);
                end
`else
                if (cnt_q == '0) begin
                    // Only a dirty read can be served cache-to-cache; a write
                    // always goes to memory (the snoop invalidates copies).
                    state_d = (!op_q && dirty_now) ? S_SUPPLY : S_MEM;
                    cnt_d   = CW'(MEM_LAT - 1);
                end
`endif
            end
            S_SUPPLY: state_d = S_DONE;
            S_MEM: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == '0) state_d = S_DONE;
            end
            S_DONE: begin
                grant_d = 3'b000;
                state_d = S_IDLE;
            end
            default: begin
                grant_d = 3'b000;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            grant_q <= 3'b000;
            rr_q    <= 2'd2;
            addr_q  <= 5'd0;
            op_q    <= 1'b0;
            block_q <= 2'd0;
            cnt_q   <= '0;
            hit_q   <= 1'b0;
            dirty_q <= 1'b0;
            err_q   <= 1'b0;
`ifdef SNOOP_TIMEOUT_EN
            ack_q   <= 3'b000;
`endif
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            rr_q    <= rr_d;
            addr_q  <= addr_d;
            op_q    <= op_d;
            block_q <= block_d;
            cnt_q   <= cnt_d;
            hit_q   <= hit_d;
            dirty_q <= dirty_d;
            err_q   <= err_d;
`ifdef SNOOP_TIMEOUT_EN
            ack_q   <= ack_d;
`endif
        end
    end

    assign grant          = grant_q;
    assign snoop_listen   = (state_q == S_SNOOP) ? ~grant_q : 3'b000;
    assign bus_addr       = addr_q;
    assign bus_op         = op_q;
    assign bus_block      = block_q;
    assign abort_mem_accs = (state_q == S_SUPPLY);
    assign mem_en         = (state_q == S_MEM);
    assign mem_we         = (state_q == S_MEM) && op_q;
    assign done           = (state_q == S_DONE) ? grant_q : 3'b000;
    assign snoop_err      = err_q;
    assign dbg_state      = state_q;
    assign dbg_hit        = hit_q;

`ifdef SNOOP_TIMEOUT_EN
    logic unused_cfg;
    assign unused_cfg = (SNOOP_CYC == 0);
`else
    logic unused_cfg;
    assign unused_cfg = (^snoop_ack) ^ (TIMEOUT_CYC == 0);
`endif

endmodule
